// File: rtl/bnn_neuron_driver.sv
// Host-side sequencer for a BNN neuron: serialises weights, activations and threshold onto the
// neuron pins, starts it, waits (bounded) for done and returns fire/popcount over a handshake.
module bnn_neuron_driver #(
   parameter int N_BYTES = 2,
   parameter int TIMEOUT = 64
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [8*N_BYTES-1:0]   in_wgt,
   input  logic [8*N_BYTES-1:0]   in_act,
   input  logic [7:0]             in_thr,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   out_fire,
   output logic [5:0]             out_popcount,
   output logic                   out_timeout,
   output logic [7:0]             nrn_ui_in,
   output logic [7:0]             nrn_uio_in,
   input  logic [7:0]             nrn_uo_out,
   output logic                   nrn_ena
);

   localparam int IDX_W = $clog2(N_BYTES) + 1;
   localparam int WC_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int SH_W  = 16 * N_BYTES + 8;
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_BYTES - 1);
   localparam logic [WC_W-1:0]  LAST_WAIT = WC_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      ST_IDLE, ST_LOAD_W, ST_LOAD_A, ST_LOAD_T, ST_START, ST_WAIT, ST_RESP
   } state_t;

   typedef enum logic [2:0] {
      CMD_IDLE   = 3'd0,
      CMD_LOAD_W = 3'd1,
      CMD_LOAD_A = 3'd2,
      CMD_LOAD_T = 3'd3,
      CMD_START  = 3'd4
   } cmd_t;

   state_t            state;
   cmd_t              cmd_q;
   logic [IDX_W-1:0]  byte_idx;
   logic [WC_W-1:0]   wait_cnt;
   logic [SH_W-1:0]   shift_q;

   assign nrn_uio_in = {5'b00000, cmd_q};

   // The whole payload is one byte stream (weights, activations, threshold, LSB first), so a single
   // shift register feeds nrn_ui_in; byte_idx only decides when the command code advances.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         cmd_q        <= CMD_IDLE;
         byte_idx     <= '0;
         wait_cnt     <= '0;
         shift_q      <= '0;
         in_ready     <= 1'b0;
         out_valid    <= 1'b0;
         out_fire     <= 1'b0;
         out_popcount <= 6'd0;
         out_timeout  <= 1'b0;
         nrn_ui_in    <= 8'd0;
         nrn_ena      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               in_ready <= 1'b1;
               if (in_valid && in_ready) begin
                  in_ready  <= 1'b0;
                  nrn_ena   <= 1'b1;
                  cmd_q     <= CMD_LOAD_W;
                  nrn_ui_in <= in_wgt[7:0];
                  shift_q   <= {in_thr, in_act, in_wgt} >> 8;
                  byte_idx  <= '0;
                  state     <= ST_LOAD_W;
               end
            end
            ST_LOAD_W: begin
               nrn_ui_in <= shift_q[7:0];
               shift_q   <= shift_q >> 8;
               if (byte_idx == LAST_IDX) begin
                  byte_idx <= '0;
                  cmd_q    <= CMD_LOAD_A;
                  state    <= ST_LOAD_A;
               end else begin
                  byte_idx <= byte_idx + 1'b1;
               end
            end
            ST_LOAD_A: begin
               nrn_ui_in <= shift_q[7:0];
               shift_q   <= shift_q >> 8;
               if (byte_idx == LAST_IDX) begin
                  byte_idx <= '0;
                  cmd_q    <= CMD_LOAD_T;
                  state    <= ST_LOAD_T;
               end else begin
                  byte_idx <= byte_idx + 1'b1;
               end
            end
            ST_LOAD_T: begin
               nrn_ui_in <= 8'd0;
               cmd_q     <= CMD_START;
               state     <= ST_START;
            end
            ST_START: begin
               cmd_q    <= CMD_IDLE;
               wait_cnt <= '0;
               state    <= ST_WAIT;
            end
            // Done wins over an expiring timeout in the same cycle.
            ST_WAIT: begin
               if (nrn_uo_out[7]) begin
                  out_fire     <= nrn_uo_out[6];
                  out_popcount <= nrn_uo_out[5:0];
                  out_timeout  <= 1'b0;
                  out_valid    <= 1'b1;
                  nrn_ena      <= 1'b0;
                  state        <= ST_RESP;
               end else if (wait_cnt == LAST_WAIT) begin
                  out_fire     <= 1'b0;
                  out_popcount <= 6'd0;
                  out_timeout  <= 1'b1;
                  out_valid    <= 1'b1;
                  nrn_ena      <= 1'b0;
                  state        <= ST_RESP;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            ST_RESP: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bnn_neuron_driver.sv
// Directed bench for bnn_neuron_driver: byte order, normal result, timeout with backpressure,
// asynchronous reset mid-transaction and back-to-back requests.
module tb_bnn_neuron_driver;

   localparam int N_BYTES = 2;
   localparam int TIMEOUT = 64;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_wgt = 16'd0;
   logic [15:0] in_act = 16'd0;
   logic [7:0]  in_thr = 8'd0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        out_fire;
   logic [5:0]  out_popcount;
   logic        out_timeout;
   logic [7:0]  nrn_ui_in;
   logic [7:0]  nrn_uio_in;
   logic [7:0]  nrn_uo_out = 8'd0;
   logic        nrn_ena;

   int checks = 0;
   int errors = 0;

   bnn_neuron_driver #(.N_BYTES(N_BYTES), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_wgt(in_wgt), .in_act(in_act), .in_thr(in_thr),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_fire(out_fire), .out_popcount(out_popcount), .out_timeout(out_timeout),
      .nrn_ui_in(nrn_ui_in), .nrn_uio_in(nrn_uio_in), .nrn_uo_out(nrn_uo_out),
      .nrn_ena(nrn_ena)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_in_ready"},  32'(in_ready), 32'd0);
      checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      checkOutput({tag, "_fire"},      32'(out_fire), 32'd0);
      checkOutput({tag, "_popcount"},  32'(out_popcount), 32'd0);
      checkOutput({tag, "_timeout"},   32'(out_timeout), 32'd0);
      checkOutput({tag, "_ui_in"},     32'(nrn_ui_in), 32'd0);
      checkOutput({tag, "_uio_in"},    32'(nrn_uio_in), 32'd0);
      checkOutput({tag, "_ena"},       32'(nrn_ena), 32'd0);
   endtask

   // Called at a falling edge where in_ready is high; returns in the first LOAD_W cycle.
   task automatic applyStimulus(input logic [15:0] w, input logic [15:0] a, input logic [7:0] t);
      checkOutput("req_in_ready", 32'(in_ready), 32'd1);
      in_wgt   = w;
      in_act   = a;
      in_thr   = t;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      in_wgt   = 16'hDEAD;
      in_act   = 16'hBEEF;
      in_thr   = 8'h55;
   endtask

   logic [7:0] exp_ui  [7] = '{8'h34, 8'h12, 8'hCD, 8'hAB, 8'h07, 8'h00, 8'h00};
   logic [7:0] exp_cmd [7] = '{8'h01, 8'h01, 8'h02, 8'h02, 8'h03, 8'h04, 8'h00};

   logic [15:0] b2b_w [2] = '{16'h00FF, 16'hFFFF};
   logic [15:0] b2b_a [2] = '{16'h0F0F, 16'h0007};
   logic [7:0]  b2b_t [2] = '{8'd8, 8'd5};
   logic        b2b_f [2] = '{1'b1, 1'b0};
   logic [5:0]  b2b_p [2] = '{6'd8, 6'd3};

   initial begin
      int accepted;
      int responses;
      int accept_neg [2];
      int resp_neg [2];

      $display("[TB] reset");
      repeat (2) @(negedge clk);
      checkResetOutputs("reset");
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("post_reset_in_ready", 32'(in_ready), 32'd1);
      checkOutput("post_reset_out_valid", 32'(out_valid), 32'd0);

      $display("[TB] byte order");
      applyStimulus(16'h1234, 16'hABCD, 8'h07);
      for (int i = 0; i < 7; i++) begin
         checkOutput($sformatf("order_ui_%0d", i), 32'(nrn_ui_in), 32'(exp_ui[i]));
         checkOutput($sformatf("order_cmd_%0d", i), 32'(nrn_uio_in), 32'(exp_cmd[i]));
         checkOutput($sformatf("order_ena_%0d", i), 32'(nrn_ena), 32'd1);
         checkOutput($sformatf("order_in_ready_%0d", i), 32'(in_ready), 32'd0);
         if (i < 6) @(negedge clk);
      end
      nrn_uo_out = 8'h85;
      @(negedge clk);
      nrn_uo_out = 8'h00;
      checkOutput("order_out_valid", 32'(out_valid), 32'd1);
      checkOutput("order_fire", 32'(out_fire), 32'd0);
      checkOutput("order_popcount", 32'(out_popcount), 32'd5);
      checkOutput("order_timeout", 32'(out_timeout), 32'd0);
      checkOutput("order_resp_ena", 32'(nrn_ena), 32'd0);
      checkOutput("order_resp_uio", 32'(nrn_uio_in), 32'd0);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checkOutput("order_done_out_valid", 32'(out_valid), 32'd0);
      checkOutput("order_done_in_ready", 32'(in_ready), 32'd1);

      $display("[TB] normal result");
      applyStimulus(16'hFFFF, 16'hFFFF, 8'd10);
      for (int n = 1; n <= 10; n++) begin
         checkOutput($sformatf("normal_out_valid_c%0d", n), 32'(out_valid), 32'(n == 10));
         if (n == 9) nrn_uo_out = 8'hD0;
         if (n < 10) @(negedge clk);
      end
      nrn_uo_out = 8'h00;
      checkOutput("normal_fire", 32'(out_fire), 32'd1);
      checkOutput("normal_popcount", 32'(out_popcount), 32'd16);
      checkOutput("normal_timeout", 32'(out_timeout), 32'd0);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checkOutput("normal_done_in_ready", 32'(in_ready), 32'd1);
      checkOutput("normal_done_out_valid", 32'(out_valid), 32'd0);

      $display("[TB] timeout and backpressure");
      applyStimulus(16'h0F0F, 16'h00FF, 8'd3);
      nrn_uo_out = 8'hFF;
      for (int n = 1; n <= 76; n++) begin
         if (n == 6) nrn_uo_out = 8'h00;
         if (n == 70) begin
            checkOutput("tmo_last_wait_out_valid", 32'(out_valid), 32'd0);
            checkOutput("tmo_last_wait_ena", 32'(nrn_ena), 32'd1);
         end
         if (n >= 71) begin
            checkOutput($sformatf("tmo_out_valid_c%0d", n), 32'(out_valid), 32'd1);
            checkOutput($sformatf("tmo_timeout_c%0d", n), 32'(out_timeout), 32'd1);
            checkOutput($sformatf("tmo_fire_c%0d", n), 32'(out_fire), 32'd0);
            checkOutput($sformatf("tmo_popcount_c%0d", n), 32'(out_popcount), 32'd0);
            checkOutput($sformatf("tmo_in_ready_c%0d", n), 32'(in_ready), 32'd0);
            checkOutput($sformatf("tmo_ena_c%0d", n), 32'(nrn_ena), 32'd0);
         end
         if (n == 76) out_ready = 1'b1;
         @(negedge clk);
      end
      out_ready = 1'b0;
      checkOutput("tmo_done_in_ready", 32'(in_ready), 32'd1);
      checkOutput("tmo_done_out_valid", 32'(out_valid), 32'd0);

      $display("[TB] reset during LOAD_A");
      applyStimulus(16'h1111, 16'h2222, 8'd1);
      repeat (2) @(negedge clk);
      checkOutput("midreset_cmd_before", 32'(nrn_uio_in), 32'd2);
      #1 rst_n = 1'b0;
      #1 checkResetOutputs("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("midreset_release_in_ready", 32'(in_ready), 32'd1);
      for (int k = 0; k < 3; k++) begin
         checkOutput($sformatf("midreset_out_valid_%0d", k), 32'(out_valid), 32'd0);
         checkOutput($sformatf("midreset_ena_%0d", k), 32'(nrn_ena), 32'd0);
         @(negedge clk);
      end

      $display("[TB] back-to-back");
      accepted   = 0;
      responses  = 0;
      accept_neg = '{0, 0};
      resp_neg   = '{0, 0};
      in_wgt     = b2b_w[0];
      in_act     = b2b_a[0];
      in_thr     = b2b_t[0];
      in_valid   = 1'b1;
      out_ready  = 1'b1;
      for (int k = 0; k < 60 && responses < 2; k++) begin
         if (out_valid) begin
            checkOutput($sformatf("b2b_fire_%0d", responses), 32'(out_fire), 32'(b2b_f[responses]));
            checkOutput($sformatf("b2b_popcount_%0d", responses), 32'(out_popcount), 32'(b2b_p[responses]));
            checkOutput($sformatf("b2b_timeout_%0d", responses), 32'(out_timeout), 32'd0);
            resp_neg[responses] = k;
            responses++;
         end
         if (nrn_ena && nrn_uio_in == 8'd0 && accepted > 0)
            nrn_uo_out = {1'b1, b2b_f[accepted-1], b2b_p[accepted-1]};
         else
            nrn_uo_out = 8'h00;
         if (in_valid && in_ready) begin
            accept_neg[accepted] = k;
            accepted++;
         end
         @(negedge clk);
         if (accepted == 1) begin
            in_wgt = b2b_w[1];
            in_act = b2b_a[1];
            in_thr = b2b_t[1];
         end
         if (accepted == 2) in_valid = 1'b0;
      end
      in_valid   = 1'b0;
      out_ready  = 1'b0;
      nrn_uo_out = 8'h00;
      checkOutput("b2b_responses", 32'(responses), 32'd2);
      checkOutput("b2b_accepts", 32'(accepted), 32'd2);
      checkOutput("b2b_first_latency", 32'(resp_neg[0] - accept_neg[0]), 32'd8);
      checkOutput("b2b_second_accept", 32'(accept_neg[1] - resp_neg[0]), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
